// File: rtl/shift_norm_pkg.sv
// Shared types and constants for the sequential shift normalizer.
//   state_t   : normalizer FSM states
//   DIR_LEFT  : normalize toward the MSB (left shift)
//   DIR_RIGHT : normalize toward the LSB (right shift)
package shift_norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_normalizer_step.sv
// One-position combinational shift of a WIDTH-bit word with zero fill.
//   d    : word to shift
//   dir  : DIR_LEFT shifts toward the MSB, DIR_RIGHT toward the LSB
//   y_c  : shifted word (combinational)
module shift_normalizer_step
    import shift_norm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    output logic [WIDTH-1:0] y_c
);

    // Single-position shift; the vacated end bit is zero-filled.
    always_comb begin
        y_c = '0;
        if (dir == DIR_RIGHT) begin
            y_c = d >> 1;
        end else begin
            y_c = d << 1;
        end
    end

endmodule

// File: rtl/shift_normalizer.sv
// Sequential normalizer: shifts a captured word one position per clock toward
// the MSB (dir=0) or LSB (dir=1) until the end bit is set, reporting the
// normalized word and the number of positions shifted.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake (in_ready high only in IDLE)
//   a, dir              : word to normalize and direction, sampled at accept
//   out_valid, out_ready: result handshake
//   y, amt, zero        : normalized word, shift count, input was all zeros
// Build option: SHIFT_NORM_EARLY_ZERO_EN finishes an all-zero input with
// amt=0 instead of iterating to the count limit.
module shift_normalizer
    import shift_norm_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic             dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [AW-1:0]    amt,
    output logic             zero
);

    localparam logic [AW-1:0] CNT_LAST = AW'(WIDTH - 1);

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] work_q, work_nxt;
    logic             dir_q, dir_nxt;
    logic [AW-1:0]    cnt_q, cnt_nxt;
    logic             azero_q, azero_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic [AW-1:0]    amt_nxt;
    logic             zero_nxt;
    logic [WIDTH-1:0] step_c;
    logic             target_c;
    logic             stop_c;

    shift_normalizer_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d   (work_q),
        .dir (dir_q),
        .y_c (step_c)
    );

    // End bit being normalized toward.
    assign target_c = (dir_q == DIR_RIGHT) ? work_q[0] : work_q[WIDTH-1];

    // Stop iterating: end bit reached or the count limit hit.
`ifdef SHIFT_NORM_EARLY_ZERO_EN
    assign stop_c = target_c || (cnt_q == CNT_LAST) || azero_q;
`else
    assign stop_c = target_c || (cnt_q == CNT_LAST);
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            dir_q     <= DIR_LEFT;
            cnt_q     <= '0;
            azero_q   <= 1'b0;
            y         <= '0;
            amt       <= '0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            work_q    <= work_nxt;
            dir_q     <= dir_nxt;
            cnt_q     <= cnt_nxt;
            azero_q   <= azero_nxt;
            y         <= y_nxt;
            amt       <= amt_nxt;
            zero      <= zero_nxt;
            // Handshake flags track the registered state one-to-one.
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state_q;
        work_nxt  = work_q;
        dir_nxt   = dir_q;
        cnt_nxt   = cnt_q;
        azero_nxt = azero_q;
        y_nxt     = y;
        amt_nxt   = amt;
        zero_nxt  = zero;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_nxt  = a;
                    dir_nxt   = dir;
                    cnt_nxt   = '0;
                    azero_nxt = (a == '0);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (stop_c) begin
                    // Result registers load only on entry to DONE.
                    y_nxt     = work_q;
                    amt_nxt   = cnt_q;
                    zero_nxt  = azero_q;
                    state_nxt = DONE;
                end else begin
                    work_nxt = step_c;
                    cnt_nxt  = cnt_q + AW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed self-checking bench for shift_normalizer (WIDTH=8).
module tb_shift_normalizer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic       dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [2:0] amt;
    logic       zero;

    int total = 0;
    int bad   = 0;

    shift_normalizer #(
        .WIDTH (8),
        .AW    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .dir       (dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .amt       (amt),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid after the accept edge; returns cycles waited (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_item(input string tag, input logic [7:0] ai, input logic di,
                            input logic [7:0] ey, input logic [2:0] ea,
                            input logic ez, input int elat);
        int lat;
        logic [7:0] back;
        chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        a        = ai;
        dir      = di;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = ~ai;
        dir      = ~di;
        wait_valid(lat);
        chk({tag, "_lat"},  32'(lat),  32'(elat));
        chk({tag, "_y"},    32'(y),    32'(ey));
        chk({tag, "_amt"},  32'(amt),  32'(ea));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
        back = di ? (y << amt) : (y >> amt);
        if (ai != 8'h00) chk({tag, "_back"}, 32'(back), 32'(ai));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        dir       = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_inrdy", 32'(in_ready), 32'd1);
        chk("rst_outs",  32'({out_valid, y, amt, zero}), 32'd0);
        rst_n = 1'b1;
        tick();

        run_item("lsb_left",  8'b0000_0001, 1'b0, 8'b1000_0000, 3'd7, 1'b0, 8);
        run_item("msb_left",  8'b1000_0000, 1'b0, 8'b1000_0000, 3'd0, 1'b0, 1);
        run_item("b4_right",  8'b0001_0000, 1'b1, 8'b0000_0001, 3'd4, 1'b0, 5);

        for (int i = 0; i < 8; i++) begin
            run_item($sformatf("swl%0d", i), 8'(1 << i), 1'b0, 8'h80, 3'(7 - i), 1'b0, 8 - i);
            run_item($sformatf("swr%0d", i), 8'(1 << i), 1'b1, 8'h01, 3'(i), 1'b0, i + 1);
        end
        run_item("mix_left",  8'b0010_1100, 1'b0, 8'b1011_0000, 3'd2, 1'b0, 3);
        run_item("mix_right", 8'b0010_1100, 1'b1, 8'b0000_1011, 3'd2, 1'b0, 3);

`ifdef SHIFT_NORM_EARLY_ZERO_EN
        run_item("zero_l", 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1);
        run_item("zero_r", 8'h00, 1'b1, 8'h00, 3'd0, 1'b1, 1);
`else
        run_item("zero_l", 8'h00, 1'b0, 8'h00, 3'd7, 1'b1, 8);
        run_item("zero_r", 8'h00, 1'b1, 8'h00, 3'd7, 1'b1, 8);
`endif

        // Back-pressure in DONE: outputs hold, inputs ignored.
        a = 8'b0000_0011; dir = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd7);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            a        = 8'(8'h11 * c);
            dir      = ~c[0];
            tick();
            chk($sformatf("bp_hold%0d", c), 32'({out_valid, in_ready, y, amt, zero}),
                32'({1'b1, 1'b0, 8'b1100_0000, 3'd6, 1'b0}));
        end
        // Release with a new item pending: not accepted on the DONE edge.
        a = 8'b0100_0000; dir = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", 32'({in_ready, out_valid}), 32'b10);
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_next_lat", 32'(lat), 32'd2);
        chk("bp_next_res", 32'({y, amt, zero}), 32'({8'b1000_0000, 3'd1, 1'b0}));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset three cycles into SHIFT.
        a = 8'b0000_0001; dir = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs",  32'({out_valid, y, amt, zero}), 32'd0);
        chk("mid_rst_inrdy", 32'(in_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_rst_outs", 32'({out_valid, y, amt, zero}), 32'd0);
        run_item("post_rst", 8'b0100_0000, 1'b0, 8'b1000_0000, 3'd1, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
